// File: rtl/permutation_pkg.sv
// Shared types and sizing helpers for the permutation engine arbiter.
package permutation_pkg;

  localparam int N_DEF     = 5;
  localparam int COUNT_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  function automatic int slice_w(input int n);
    return n * n;
  endfunction

  function automatic int cnt_w(input int count);
    return (count < 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/permutation_arbiter_if.sv
// Requester and engine signal bundle; master is the arbiter side.
interface permutation_arbiter_if import permutation_pkg::*; #(
  parameter int W = slice_w(N_DEF)
) ();

  logic         req0, req1;
  logic [W-1:0] in0, in1;
  logic         gnt0, gnt1;
  logic         put0, put1;
  logic         done0, done1;
  logic [W-1:0] out;
  logic         eng_start;
  logic [W-1:0] eng_in;
  logic         eng_put_input;
  logic         eng_ready;
  logic [W-1:0] eng_out;

  modport master (
    input  req0, req1, in0, in1, eng_put_input, eng_ready, eng_out,
    output gnt0, gnt1, put0, put1, done0, done1, out, eng_start, eng_in
  );

  modport slave (
    output req0, req1, in0, in1, eng_put_input, eng_ready, eng_out,
    input  gnt0, gnt1, put0, put1, done0, done1, out, eng_start, eng_in
  );

endinterface

// File: rtl/perm_slice_counter.sv
// Modulo-COUNT slice counter; co flags the put that completes a permutation.
module perm_slice_counter import permutation_pkg::*; #(
  parameter int COUNT = COUNT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic co
);

  localparam int            CW   = cnt_w(COUNT);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign co = en & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = co ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/permutation_arbiter.sv
// Round-robin share of one permutation engine between two requesters.
//   state   | meaning
//   S_IDLE  | arbitrate pending requests
//   S_START | one-cycle engine start, slice counter cleared
//   S_LOAD  | forward COUNT put strobes to the granted requester
//   S_WAIT  | wait for engine ready (result valid)
//   S_DONE  | done pulse, result on out, round-robin pointer updated
module permutation_arbiter import permutation_pkg::*; #(
  parameter int N     = N_DEF,
  parameter int COUNT = COUNT_DEF
) (
  input logic                  clk,
  input logic                  rst,
  permutation_arbiter_if.master bus
);

  localparam int W = slice_w(N);

  state_e       state_q, state_d;
  logic         last_q, last_d;
  logic         sel_q, sel_d;
  logic         gnt_q, gnt_d;
  logic         in_load, cnt_en, cnt_co;
  logic [W-1:0] eng_in_w;

  perm_slice_counter #(.COUNT(COUNT)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q == S_START),
    .en  (cnt_en),
    .co  (cnt_co)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          // on a tie, serve whoever was not served last
          sel_d   = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
          gnt_d   = 1'b1;
          state_d = S_START;
        end
      end
      S_START: state_d = S_LOAD;
      S_LOAD:  if (cnt_co) state_d = S_WAIT;
      S_WAIT:  if (bus.eng_ready) state_d = S_DONE;
      S_DONE: begin
        last_d  = sel_q;
        gnt_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        gnt_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      gnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  assign in_load = (state_q == S_LOAD);
  assign cnt_en  = in_load & bus.eng_put_input;

  assign bus.gnt0      = gnt_q & ~sel_q;
  assign bus.gnt1      = gnt_q & sel_q;
  assign bus.put0      = cnt_en & bus.gnt0;
  assign bus.put1      = cnt_en & bus.gnt1;
  assign bus.done0     = (state_q == S_DONE) & bus.gnt0;
  assign bus.done1     = (state_q == S_DONE) & bus.gnt1;
  assign bus.eng_start = (state_q == S_START);

  assign eng_in_w   = bus.gnt1 ? bus.in1 : bus.in0;
  assign bus.eng_in = eng_in_w;
  assign bus.out    = bus.eng_out;

endmodule

// File: tb/tb_permutation_arbiter.sv
// Scoreboarded bench: emulated engine, transaction-level round-robin model.
module tb_permutation_arbiter;
  import permutation_pkg::*;

  localparam int N     = 5;
  localparam int COUNT = 64;
  localparam int W     = N * N;

  typedef struct {
    int           idx;
    logic [W-1:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  permutation_arbiter_if #(.W(W)) bus ();

  permutation_arbiter #(.N(N), .COUNT(COUNT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t         exp_q[$];
  int           n_total = 0;
  int           n_pass  = 0;
  bit           model_last = 1'b1;
  bit           stray_en = 1'b0;
  bit           gap3 = 1'b0;
  bit           ready_hold = 1'b0;
  int           loaded = 0;
  int           phase = 0;   // engine view: 0 idle, 1 load, 2 busy, 3 result
  int           busy_cnt = 0;
  int           lcyc = 0;
  int           done_cnt = 0;
  logic [W-1:0] cur_res = '0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // engine emulator plus per-cycle strobe forwarding checks
  initial begin : engine
    bit in_load, strobe, e0, e1;
    int widx;
    bus.eng_put_input = 1'b0;
    bus.eng_ready     = 1'b1;
    bus.eng_out       = '0;
    bus.in0           = '0;
    bus.in1           = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        phase = 0;
        loaded = 0;
        bus.eng_put_input = 1'b0;
        bus.eng_ready = 1'b1;
        continue;
      end
      in_load = (phase == 1);
      if (bus.eng_start) begin
        phase = 1;
        loaded = 0;
        lcyc = 0;
        if (exp_q.size() > 0) cur_res = exp_q[0].res;
      end
      if (in_load) begin
        strobe = gap3 ? (lcyc % 3 == 2) : ($urandom_range(0, 1) == 1);
        lcyc++;
      end else begin
        strobe = stray_en && ($urandom_range(0, 3) == 0);
      end
      case (phase)
        1:       bus.eng_ready = ready_hold ? 1'b1 : 1'($urandom_range(0, 1));
        2:       bus.eng_ready = ready_hold;
        default: bus.eng_ready = 1'b1;
      endcase
      bus.eng_out       = (phase >= 2) ? cur_res : W'($urandom);
      bus.in0           = W'($urandom);
      bus.in1           = W'($urandom);
      bus.eng_put_input = strobe;
      #1;
      widx = (exp_q.size() > 0) ? exp_q[0].idx : -1;
      e0 = strobe && in_load && (widx == 0);
      e1 = strobe && in_load && (widx == 1);
      if (strobe || bus.put0 || bus.put1) begin
        chk(bus.put0 === e0, "put0", longint'(bus.put0), longint'(e0));
        chk(bus.put1 === e1, "put1", longint'(bus.put1), longint'(e1));
      end
      if (e0 || e1) begin
        chk(bus.eng_in === (e1 ? bus.in1 : bus.in0), "eng_in", longint'(bus.eng_in),
            longint'(e1 ? bus.in1 : bus.in0));
        chk(bus.gnt0 === (widx == 0) && bus.gnt1 === (widx == 1), "gnt_load",
            longint'({bus.gnt1, bus.gnt0}), longint'(widx == 1 ? 2 : 1));
      end
      if (in_load && strobe) begin
        loaded++;
        if (loaded == COUNT) begin
          phase = 2;
          busy_cnt = $urandom_range(0, 5);
        end
      end else if (phase == 2) begin
        if (busy_cnt == 0) phase = 3;
        else busy_cnt--;
      end
      if ((bus.done0 || bus.done1) && phase != 1) phase = 0;
    end
  end

  // scoreboard monitor: one expected entry per done pulse
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && (bus.done0 || bus.done1)) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "done_unexpected", longint'({bus.done1, bus.done0}), 0);
        end else begin
          e = exp_q.pop_front();
          chk({bus.done1, bus.done0} === ((e.idx == 1) ? 2'b10 : 2'b01), "done_idx",
              longint'({bus.done1, bus.done0}), longint'((e.idx == 1) ? 2 : 1));
          chk(bus.out === e.res, "out", longint'(bus.out), longint'(e.res));
          chk(loaded == COUNT, "puts_before_done", longint'(loaded), longint'(COUNT));
          done_cnt++;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    model_last = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    chk({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.eng_start, bus.put0, bus.put1} === 7'b0,
        "reset_outputs",
        longint'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.eng_start, bus.put0, bus.put1}), 0);
    chk(bus.eng_in === bus.in0, "reset_eng_in", longint'(bus.eng_in), longint'(bus.in0));
    chk(bus.out === bus.eng_out, "reset_out", longint'(bus.out), longint'(bus.eng_out));
    rst = 1'b1;
  endtask

  // issue one arbitration; expected winner comes from the round-robin rule
  task automatic run_arb(input bit r0, input bit r1, input int drop_after, input int exp_lat);
    int w, start_cnt, cyc, n;
    w = (r0 && r1) ? (model_last ? 0 : 1) : (r1 ? 1 : 0);
    model_last = (w == 1);
    exp_q.push_back(exp_t'{idx: w, res: W'($urandom)});
    bus.req0 = r0;
    bus.req1 = r1;
    start_cnt = done_cnt;
    n = 0;
    while (n < 4) begin
      @(negedge clk);
      #3;
      n++;
      if (bus.eng_start) break;
    end
    chk(n == exp_lat && bus.eng_start === 1'b1, "start_latency", longint'(n), longint'(exp_lat));
    chk(bus.gnt0 === (w == 0) && bus.gnt1 === (w == 1), "start_gnt",
        longint'({bus.gnt1, bus.gnt0}), longint'(w == 1 ? 2 : 1));
    cyc = 0;
    while (done_cnt == start_cnt && cyc < 5000) begin
      @(negedge clk);
      #3;
      cyc++;
      if (drop_after >= 0 && phase == 1 && loaded >= drop_after) begin
        if (w == 0) bus.req0 = 1'b0;
        else bus.req1 = 1'b0;
      end
    end
    if (done_cnt == start_cnt) begin
      chk(1'b0, "txn_timeout", longint'(cyc), 5000);
      exp_q.delete();
    end
    if (w == 0) bus.req0 = 1'b0;
    else bus.req1 = 1'b0;
  endtask

  initial begin : stim
    int cyc, pend;
    bit r0, r1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;

    do_reset();
    run_arb(1'b1, 1'b0, -1, 1);

    do_reset();
    run_arb(1'b1, 1'b1, -1, 1);
    run_arb(1'b1, 1'b1, -1, 2);
    run_arb(1'b1, 1'b1, -1, 2);
    run_arb(1'b1, 1'b1, -1, 2);
    run_arb(1'b1, 1'b0, -1, 2);

    ready_hold = 1'b1;
    run_arb(1'b0, 1'b1, -1, 2);
    ready_hold = 1'b0;

    gap3 = 1'b1;
    stray_en = 1'b1;
    run_arb(1'b1, 1'b0, -1, 2);
    run_arb(1'b0, 1'b1, -1, 2);
    gap3 = 1'b0;

    do_reset();
    run_arb(1'b1, 1'b0, 10, 1);
    run_arb(1'b1, 1'b1, -1, 2);
    run_arb(1'b1, 1'b0, -1, 2);

    // abort mid-load, then a fresh transaction must need all COUNT puts
    exp_q.push_back(exp_t'{idx: 0, res: W'($urandom)});
    bus.req0 = 1'b1;
    cyc = 0;
    while (!(phase == 1 && loaded >= 30) && cyc < 2000) begin
      @(negedge clk);
      #3;
      cyc++;
    end
    chk(phase == 1 && loaded >= 30, "reach_put30", longint'(loaded), 30);
    rst = 1'b0;
    #1;
    chk({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.eng_start, bus.put0, bus.put1} === 7'b0,
        "abort_outputs",
        longint'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.eng_start, bus.put0, bus.put1}), 0);
    do_reset();
    run_arb(1'b0, 1'b1, -1, 1);

    pend = -1;
    for (int t = 0; t < 10; t++) begin
      stray_en   = 1'($urandom_range(0, 1));
      gap3       = ($urandom_range(0, 3) == 0);
      ready_hold = ($urandom_range(0, 3) == 0);
      r0 = 1'($urandom_range(0, 1)) || (pend == 0);
      r1 = 1'($urandom_range(0, 1)) || (pend == 1);
      if (!r0 && !r1) r0 = 1'b1;
      pend = (r0 && r1) ? (model_last ? 1 : 0) : -1;
      run_arb(r0, r1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : -1, 2);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/permutation_arbiter.md
# permutation_arbiter

Shares one Permutation engine between two requesters (e.g. hash core and test/self-check port) with round-robin fairness. Each transaction runs one full permutation: one engine start, then exactly COUNT input slices fed on the engine's put-input strobes, then the result handed back. It sits between the requesters and the single Permutation instance, and drives that instance's start/in and observes its putInput/ready/out.

## Interface

**Parameters**
- `N`, 5, matrix dimension; slice width W = N*N.
- `COUNT`, 64, input slices per permutation (must be ≥ 2).

**Ports**
- `clk`, input, 1, single clock, rising edge.
- `rst`, input, 1, reset; asynchronous, active-low.
- `req0`, `req1`, input, 1, level request; held until matching done pulse.
- `in0`, `in1`, input, W, requester slice data, valid whenever its put strobe is high.
- `gnt0`, `gnt1`, output, 1, registered grant; at most one high.
- `put0`, `put1`, output, 1, forwarded slice strobe = `eng_put_input & gntX`.
- `done0`, `done1`, output, 1, one-cycle completion pulse to granted requester.
- `out`, output, W, `eng_out` passthrough; valid in the done cycle.
- `eng_start`, output, 1, one-cycle start pulse to engine.
- `eng_in`, output, W, `gnt1 ? in1 : in0`.
- `eng_put_input`, input, 1, engine consumes `eng_in` this cycle.
- `eng_ready`, input, 1, engine idle / result valid.
- `eng_out`, input, W, engine result.

## Operation

- States: IDLE, START, LOAD, WAIT, DONE; registered, binary-encoded.
- IDLE:
  - No request: stay.
  - One request: grant it.
  - Both requesting: grant the requester not served last.
  - Priority pointer `last` resets to 1, so req0 wins the first tie.
  - On grant: `gntX` = 1, go to START.
- START: `eng_start` = 1 for this single cycle; slice counter cleared; go to LOAD.
- LOAD:
  - Each cycle with `eng_put_input` = 1 increments the counter and forwards the strobe on `putX`.
  - The put that brings the counter to COUNT (co, counter = COUNT-1 with put) moves the FSM to WAIT; the counter wraps to 0.
- WAIT: stay until `eng_ready` = 1, then go to DONE. `eng_ready` is ignored in START and LOAD, where the engine may still report idle.
- DONE:
  - `doneX` = 1 for one cycle; `out` is valid.
  - `last` ← granted index; go to IDLE.
  - Grant drops on the following edge.
- `eng_put_input` outside LOAD is ignored: no counter change, `put0`/`put1` stay 0.
- Requester dropping `req` mid-transaction is ignored. The transaction completes, the done pulse is still issued, and `last` updates.
- `req` still high in IDLE after DONE is treated as a new request and is arbitrated fairly against the other requester.

## Timing

- Reset (async, `rst` = 0):
  - State IDLE, counter 0, `last` = 1.
  - `gnt0`, `gnt1`, `done0`, `done1`, `eng_start`, `put0`, `put1` all 0.
  - `eng_in` = `in0`; `out` follows `eng_out`.
- Reset asserted mid-transaction aborts immediately: grant and start are dropped, no done pulse. The engine must be reset by the same `rst`.
- Request sampled high at edge k:
  - `gnt` high and `eng_start` high during cycle k+1 (START).
  - LOAD from k+2.
- Overhead per transaction: 1 cycle IDLE + 1 cycle START + 1 cycle DONE, plus engine time.
- Minimum gap between two back-to-back grants: done cycle, then IDLE cycle, then the new grant.
- `putX` and `eng_in` are combinational and zero-latency relative to `eng_put_input`.
- `doneX` and `gntX` are registered, decoded from state only.

## Structure

- Shared package `permutation_pkg`: state encodings (IDLE/START/LOAD/WAIT/DONE), W = N*N helper, slice-counter width clog2(COUNT).
- Sub-module `perm_slice_counter`:
  - Modulo-COUNT up-counter.
  - Inputs: clr, en. Output: co.
  - co is combinational: (cnt == COUNT-1) & en.
- Top: FSM, round-robin pointer, muxes.

## Test plan

- Reset then single request:
  - req0 = 1 → gnt0 and eng_start at cycle 1.
  - 64 eng_put_input strobes → 64 put0 pulses, eng_in = in0 each time.
  - eng_ready high → done0 one cycle, out = eng_out.
- Simultaneous req0 = req1 = 1 from reset:
  - Grant order 0, 1, 0, 1 across four transactions.
  - gnt1 never overlaps gnt0; put1 = 0 while gnt0 is high.
- eng_ready held high throughout: no early exit from LOAD; done only after the 64th put.
- Strobes with gaps (put every 3rd cycle), plus strobes injected in IDLE/WAIT: exactly 64 counted; stray strobes produce no putX.
- req0 dropped after 10 puts: transaction completes, done0 pulses, the next tie goes to req1.
- rst asserted at put 30: all outputs 0 immediately. After release, req1 alone → gnt1, counter restarts from 0 (64 fresh puts needed).
